// File: rtl/feature_pkg.sv
// Shared types for the feature collector: the buffered feature record and the collector FSM
// state. Record fields are sized for the widest supported image and strength.
package feature_pkg;

  localparam int unsigned FeatXMaxW = 16;
  localparam int unsigned FeatYMaxW = 16;
  localparam int unsigned FeatSMaxW = 16;

  typedef struct packed {
    logic [FeatXMaxW-1:0] x;
    logic [FeatYMaxW-1:0] y;
    logic [FeatSMaxW-1:0] strength;
  } feature_t;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } collect_state_e;

endpackage

// File: rtl/feature_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap bit so full and
// empty can be told apart; a push while full is dropped even if a pop happens that cycle.
module feature_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_i && !full_o) begin
      mem_d[wr_q[AW-1:0]] = wdata_i;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (pop_i && !empty_o) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/feature_collector.sv
// Turns the suppressed per-pixel raster stream into (x, y, strength) feature records, capping
// the per-frame count, buffering in a FWFT FIFO and reporting frame completion and drops.
module feature_collector
  import feature_pkg::*;
#(
  parameter int unsigned BW           = 8,
  parameter int unsigned IM_WIDTH     = 640,
  parameter int unsigned IM_HEIGHT    = 480,
  parameter int unsigned MAX_FEATURES = 512,
  parameter int unsigned FIFO_DEPTH   = 64,
  localparam int unsigned XW          = $clog2(IM_WIDTH),
  localparam int unsigned YW          = $clog2(IM_HEIGHT),
  localparam int unsigned CW          = $clog2(MAX_FEATURES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [BW-1:0] strength_in,
  input  logic          feature_flag,
  output logic          feat_valid,
  input  logic          feat_ready,
  output logic [XW-1:0] feat_x,
  output logic [YW-1:0] feat_y,
  output logic [BW-1:0] feat_strength,
  output logic          frame_done,
  output logic [CW-1:0] frame_count,
  output logic          dropped,
  output logic          busy
);

  collect_state_e state_q, state_d;
  logic [XW-1:0]  x_q, x_d, px;
  logic [YW-1:0]  y_q, y_d, py;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_cur;
  logic [CW-1:0]  frame_count_q, frame_count_d;
  logic           dropped_q, dropped_d;
  logic           frame_done_q, frame_done_d;
  logic           active, accept, last_col, last_pix;
  logic           fifo_full, fifo_empty;
  feature_t       push_rec, head;
  logic           unused_head;

  always_comb begin
    // A frame_start pixel is processed as (0,0) of a fresh frame whatever the state.
    active   = frame_start || (state_q == StCollect);
    px       = frame_start ? '0 : x_q;
    py       = frame_start ? '0 : y_q;
    cnt_cur  = frame_start ? '0 : cnt_q;
    accept   = active && feature_flag && (cnt_cur < CW'(MAX_FEATURES)) && !fifo_full;
    last_col = (px == XW'(IM_WIDTH - 1));
    last_pix = last_col && (py == YW'(IM_HEIGHT - 1));

    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    dropped_d     = dropped_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (active) begin
      state_d   = StCollect;
      cnt_d     = cnt_cur + CW'(accept);
      dropped_d = (dropped_q && !frame_start) || (feature_flag && !accept);
      x_d       = last_col ? '0 : px + XW'(1);
      y_d       = last_col ? py + YW'(1) : py;
      if (last_pix) begin
        state_d       = StIdle;
        y_d           = '0;
        frame_done_d  = 1'b1;
        frame_count_d = cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      dropped_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      dropped_q     <= dropped_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    push_rec          = '0;
    push_rec.x        = FeatXMaxW'(px);
    push_rec.y        = FeatYMaxW'(py);
    push_rec.strength = FeatSMaxW'(strength_in);
  end

  feature_fifo #(
    .Width ($bits(feature_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (accept),
    .wdata_i (push_rec),
    .pop_i   (feat_valid && feat_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Payload is forced to zero while empty so nothing stale shows after reset.
  assign feat_valid    = !fifo_empty;
  assign feat_x        = fifo_empty ? '0 : head.x[XW-1:0];
  assign feat_y        = fifo_empty ? '0 : head.y[YW-1:0];
  assign feat_strength = fifo_empty ? '0 : head.strength[BW-1:0];
  assign unused_head   = ^head;

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign dropped     = dropped_q;
  assign busy        = (state_q == StCollect);

endmodule

// File: tb/tb_feature_collector.sv
// Bench for feature_collector on an 8x4 image: a hand-computed vector table, directed frame
// sequences, and randomized traffic checked against a pixel-index/queue reference model.
module tb_feature_collector;

  localparam int unsigned BW = 8, W = 8, H = 4, MaxF = 6, Depth = 4;

  logic          clk = 1'b0;
  logic          rst, frame_start, feature_flag, feat_ready;
  logic [BW-1:0] strength_in;
  logic          feat_valid, frame_done, dropped, busy;
  logic [2:0]    feat_x;
  logic [1:0]    feat_y;
  logic [BW-1:0] feat_strength;
  logic [2:0]    frame_count;

  feature_collector #(
    .BW           (BW),
    .IM_WIDTH     (W),
    .IM_HEIGHT    (H),
    .MAX_FEATURES (MaxF),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .strength_in   (strength_in),
    .feature_flag  (feature_flag),
    .feat_valid    (feat_valid),
    .feat_ready    (feat_ready),
    .feat_x        (feat_x),
    .feat_y        (feat_y),
    .feat_strength (feat_strength),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .dropped       (dropped),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {int x; int y; int s;} rec_t;
  rec_t mq[$];
  rec_t popped[$];
  bit   m_in, m_drop, m_done;
  int   m_pos, m_cnt, m_fcnt;

  typedef struct {
    bit r; bit fs; bit fl; int s; bit rdy;
    int v; int x; int y; int st; int d; int c; int dr; int b;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] pack(int v, int x, int y, int s, int d, int c, int dr, int b);
    logic [19:0] r;
    r = {v[0], x[2:0], y[1:0], s[7:0], d[0], c[2:0], dr[0], b[0]};
    return r;
  endfunction

  function automatic logic [19:0] dut_vec();
    return {feat_valid, feat_x, feat_y, feat_strength, frame_done, frame_count, dropped, busy};
  endfunction

  function automatic logic [19:0] model_vec();
    if (mq.size() > 0)
      return pack(1, mq[0].x, mq[0].y, mq[0].s, int'(m_done), m_fcnt, int'(m_drop), int'(m_in));
    return pack(0, 0, 0, 0, int'(m_done), m_fcnt, int'(m_drop), int'(m_in));
  endfunction

  // Reference: a frame is a run of W*H pixel indices; the FIFO is a bounded queue.
  task automatic model_step(input bit r, input bit fs, input bit fl, input int s, input bit rdy);
    bit full, pop;
    if (r) begin
      m_in = 0; m_pos = 0; m_cnt = 0; m_fcnt = 0; m_drop = 0; m_done = 0;
      mq.delete();
      return;
    end
    full   = (mq.size() == Depth);
    pop    = (mq.size() > 0) && rdy;
    m_done = 0;
    if (fs) begin
      m_in = 1; m_pos = 0; m_cnt = 0; m_drop = 0;
    end
    if (pop) void'(mq.pop_front());
    if (m_in) begin
      if (fl) begin
        if (m_cnt < MaxF && !full) begin
          mq.push_back('{m_pos % W, m_pos / W, s});
          m_cnt++;
        end else begin
          m_drop = 1;
        end
      end
      m_pos++;
      if (m_pos == W * H) begin
        m_in = 0; m_done = 1; m_fcnt = m_cnt;
      end
    end
  endtask

  task automatic drive_tick(input bit r, input bit fs, input bit fl, input int s, input bit rdy);
    rst = r; frame_start = fs; feature_flag = fl; strength_in = s[BW-1:0]; feat_ready = rdy;
    if (feat_valid && rdy && !r) popped.push_back('{int'(feat_x), int'(feat_y), int'(feat_strength)});
    @(posedge clk);
    #1;
    model_step(r, fs, fl, s, rdy);
  endtask

  task automatic cyc(input bit r, input bit fs, input bit fl, input int s, input bit rdy,
                     input string tag);
    drive_tick(r, fs, fl, s, rdy);
    check(tag, 64'(dut_vec()), 64'(model_vec()));
  endtask

  function automatic logic [63:0] rec_key(rec_t rc);
    return 64'(rc.x * 65536 + rc.y * 256 + rc.s);
  endfunction

  initial begin
    rst = 1'b1; frame_start = 1'b0; feature_flag = 1'b0; feat_ready = 1'b0; strength_in = '0;

    // r fs fl s rdy | valid x y strength done count dropped busy
    tbl[0]  = '{1, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 5,  1,  0, 0, 0, 0,  0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 9,  0,  1, 0, 0, 9,  0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0,  0,  1, 0, 0, 9,  0, 0, 0, 1};
    tbl[4]  = '{0, 0, 1, 11, 0,  1, 0, 0, 9,  0, 0, 0, 1};
    tbl[5]  = '{0, 0, 1, 12, 0,  1, 0, 0, 9,  0, 0, 0, 1};
    tbl[6]  = '{0, 0, 1, 13, 0,  1, 0, 0, 9,  0, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 14, 1,  1, 2, 0, 11, 0, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 0,  1,  1, 3, 0, 12, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 1, 20, 1,  1, 4, 0, 13, 0, 0, 1, 1};
    tbl[10] = '{0, 0, 1, 21, 1,  1, 7, 0, 20, 0, 0, 1, 1};
    tbl[11] = '{0, 0, 1, 22, 1,  1, 0, 1, 21, 0, 0, 1, 1};
    tbl[12] = '{0, 0, 1, 23, 0,  1, 0, 1, 21, 0, 0, 1, 1};
    tbl[13] = '{1, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbl[14] = '{0, 0, 1, 7,  1,  0, 0, 0, 0,  0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      drive_tick(tbl[i].r, tbl[i].fs, tbl[i].fl, tbl[i].s, tbl[i].rdy);
      check($sformatf("table[%0d]", i), 64'(dut_vec()),
            64'(pack(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].d, tbl[i].c,
                     tbl[i].dr, tbl[i].b)));
    end

    // Single frame, two features, consumer always ready.
    cyc(1, 0, 0, 0, 1, "a_rst");
    popped.delete();
    for (int p = 0; p < 32; p++) begin
      cyc(0, p == 0, (p == 2) || (p == 31), (p == 2) ? 9 : 200, 1, "a_frame");
      if (p == 30) check("a_no_early_done", 64'(frame_done), 64'(0));
    end
    check("a_done", 64'({frame_done, frame_count, dropped, busy}), 64'({1'b1, 3'd2, 1'b0, 1'b0}));
    cyc(0, 0, 0, 0, 1, "a_tail");
    check("a_done_pulse", 64'({frame_done, frame_count}), 64'({1'b0, 3'd2}));
    cyc(0, 0, 0, 0, 1, "a_tail");
    check("a_nrec", 64'(popped.size()), 64'(2));
    if (popped.size() >= 2) begin
      check("a_rec0", rec_key(popped[0]), 64'(2 * 65536 + 0 * 256 + 9));
      check("a_rec1", rec_key(popped[1]), 64'(7 * 65536 + 3 * 256 + 200));
    end

    // Eight features against a cap of six; next frame clears dropped.
    cyc(1, 0, 0, 0, 1, "b_rst");
    popped.delete();
    for (int p = 0; p < 32; p++) cyc(0, p == 0, p < 8, 40 + p, 1, "b_frame");
    check("b_done", 64'({frame_done, frame_count, dropped}), 64'({1'b1, 3'd6, 1'b1}));
    cyc(0, 1, 0, 0, 1, "b_next");
    check("b_drop_clr", 64'({dropped, busy}), 64'({1'b0, 1'b1}));
    check("b_nrec", 64'(popped.size()), 64'(6));

    // Abort at pixel 13: restart as (0,0), completion 32 cycles after the abort.
    cyc(1, 0, 0, 0, 1, "c_rst");
    for (int p = 0; p < 13; p++) cyc(0, p == 0, 0, 0, 1, "c_pre");
    popped.delete();
    for (int i = 0; i < 32; i++) begin
      cyc(0, i == 0, i == 0, 77, 1, "c_frame");
      check("c_done_timing", 64'(frame_done), 64'(i == 31));
    end
    check("c_count", 64'(frame_count), 64'(1));
    if (popped.size() >= 1) check("c_rec0", rec_key(popped[0]), 64'(77));
    else check("c_nrec", 64'(popped.size()), 64'(1));

    // Reset mid-frame with three records buffered, then the stream is ignored.
    cyc(1, 0, 0, 0, 0, "d_rst");
    for (int p = 0; p < 4; p++) cyc(0, p == 0, p < 3, p + 1, 0, "d_fill");
    check("d_full_head", 64'({feat_valid, feat_strength}), 64'({1'b1, 8'd1}));
    cyc(1, 0, 0, 0, 0, "d_rst_mid");
    check("d_after_rst", 64'({feat_valid, busy}), 64'(0));
    for (int p = 0; p < 3; p++) begin
      cyc(0, 0, 1, 50, 0, "d_idle");
      check("d_ignored", 64'({feat_valid, busy}), 64'(0));
    end

    // Randomized traffic against the reference model.
    cyc(1, 0, 0, 0, 0, "r_rst");
    for (int i = 0; i < 2000; i++) begin
      bit r, fs, fl, rdy;
      r   = ($urandom_range(0, 499) == 0);
      fs  = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 2) == 0);
      rdy = ((i / 100) % 3 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      cyc(r, fs, fl, int'($urandom_range(0, 255)), rdy, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
